// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane writes, registered read-first
// read port, and an MMIO window (cycle counter, GPIO, misalignment status).
module data_mem_responder #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE   = 32'h0001_0000,
  parameter logic [63:0]      CYCLE_INIT  = 64'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] data_mem_addr,
  input  logic [XLEN-1:0] data_mem_wdata,
  input  logic [2:0]      data_mem_we,
  output logic [XLEN-1:0] data_mem_out,
  output logic [XLEN-1:0] gpio_out,
  output logic            misalign_err
);

  localparam int unsigned     AW       = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] MMIO_END = MMIO_BASE + XLEN'(64);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] out_q, out_d;
  logic [XLEN-1:0] gpio_q, gpio_d;
  logic [63:0]     cycle_q;
  logic [31:0]     shadow_q, shadow_d;
  logic            err_q, err_d;
  logic [7:0]      errcnt_q, errcnt_d;

  logic            ram_hit_s, mmio_hit_s, misalign_s, mmio_we_s;
  logic            is_byte_s, is_half_s, is_word_s;
  logic [3:0]      mmio_reg_s, ram_be_s, ram_wr_s;
  logic [XLEN-1:0] ram_wd_s;
  logic [AW-1:0]   word_idx_s;

  assign ram_hit_s  = data_mem_addr < MMIO_BASE;
  assign mmio_hit_s = (data_mem_addr >= MMIO_BASE) && (data_mem_addr < MMIO_END);
  assign mmio_reg_s = data_mem_addr[5:2];
  assign word_idx_s = data_mem_addr[2 +: AW];
  assign is_byte_s  = data_mem_we == 3'b001;
  assign is_half_s  = data_mem_we == 3'b010;
  assign is_word_s  = data_mem_we == 3'b100;

  // Narrow MMIO writes are silently dropped, so only RAM halves and word writes can misalign.
  assign misalign_s = (is_half_s && data_mem_addr[0] && ram_hit_s) ||
                      (is_word_s && (data_mem_addr[1:0] != 2'b00) && (ram_hit_s || mmio_hit_s));
  assign mmio_we_s  = mmio_hit_s && is_word_s && (data_mem_addr[1:0] == 2'b00);
  assign ram_wr_s   = ram_be_s & {4{ram_hit_s && !misalign_s}};

  // Lane enables and replicated write data for the RAM.
  always_comb begin
    ram_be_s = 4'b0000;
    ram_wd_s = '0;
    if (is_byte_s) begin
      ram_be_s = 4'b0001 << data_mem_addr[1:0];
      ram_wd_s = {4{data_mem_wdata[7:0]}};
    end else if (is_half_s) begin
      ram_be_s = data_mem_addr[1] ? 4'b1100 : 4'b0011;
      ram_wd_s = {2{data_mem_wdata[15:0]}};
    end else if (is_word_s) begin
      ram_be_s = 4'b1111;
      ram_wd_s = data_mem_wdata;
    end else begin
      ram_be_s = 4'b0000;
      ram_wd_s = '0;
    end
  end

  // Next-state for read data and MMIO registers; the RAM is read before this edge's write.
  always_comb begin
    out_d    = '0;
    gpio_d   = gpio_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    if (ram_hit_s) begin
      out_d = mem_q[word_idx_s];
    end else if (mmio_hit_s) begin
      case (mmio_reg_s)
        4'd0:    out_d = cycle_q[31:0];
        4'd1:    out_d = shadow_q;
        4'd2:    out_d = gpio_q;
        4'd3:    out_d = {{(XLEN-16){1'b0}}, errcnt_q, 7'b000_0000, err_q};
        default: out_d = '0;
      endcase
    end else begin
      out_d = '0;
    end
    if (mmio_hit_s && (mmio_reg_s == 4'd0)) begin
      shadow_d = cycle_q[63:32];
    end else begin
      shadow_d = shadow_q;
    end
    if (mmio_we_s && (mmio_reg_s == 4'd2)) begin
      gpio_d = data_mem_wdata;
    end else begin
      gpio_d = gpio_q;
    end
    if (misalign_s) begin
      err_d    = 1'b1;
      errcnt_d = (errcnt_q == 8'hFF) ? 8'hFF : errcnt_q + 8'd1;
    end else if (mmio_we_s && (mmio_reg_s == 4'd3) && (data_mem_wdata == '0)) begin
      err_d    = 1'b0;
      errcnt_d = 8'h00;
    end else begin
      err_d    = err_q;
      errcnt_d = errcnt_q;
    end
  end

  // RAM array has no reset; lanes are written independently.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_s[b]) begin
        mem_q[word_idx_s][8*b +: 8] <= ram_wd_s[8*b +: 8];
      end
    end
  end

  // Output and MMIO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      gpio_q   <= '0;
      cycle_q  <= CYCLE_INIT;
      shadow_q <= 32'd0;
      err_q    <= 1'b0;
      errcnt_q <= 8'h00;
    end else begin
      out_q    <= out_d;
      gpio_q   <= gpio_d;
      cycle_q  <= cycle_q + 64'd1;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign data_mem_out = out_q;
  assign gpio_out     = gpio_q;
  assign misalign_err = err_q;

endmodule
